// File: rtl/secded_pkg.sv
// Shared definitions for the SECDED word sink: codeword geometry, data bit
// positions inside the corrected codeword, sink FSM states and the extractor.
package secded_pkg;

    localparam int CODE_W = 13;
    localparam int DATA_W = 8;

    // Codeword bit that carries data bit i (bit 0 and powers of two are parity).
    localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};

    typedef enum logic [0:0] {
        OK    = 1'b0,
        FAULT = 1'b1
    } sink_state_t;

    // Gather the data bits out of a corrected codeword, LSB first.
    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < DATA_W; i++) begin
            d[i] = code[DATA_POS[i]];
        end
        return d;
    endfunction

endpackage

// File: rtl/secded_word_sink_fifo.sv
// Synchronous FIFO with a registered head: rdata_o only changes when the head
// entry changes, and holds its last value once the FIFO drains.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] rdata_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d, remain;
    logic [W-1:0]     head_q, head_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = head_q;

    // Full/empty come from the registered count, so a same-cycle pop never
    // makes room for a push.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign remain  = count_q - CNT_W'(pop_ok);

    // Next pointers, count and head; a push into an (effectively) empty FIFO
    // bypasses the array so the byte is at the head one clock after accept.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = remain + CNT_W'(push_ok);
        head_d   = head_q;
        if (remain == '0) begin
            if (push_ok) head_d = wdata_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Control state and head register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // Storage array; contents are meaningless once count is reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/secded_word_sink.sv
// SECDED word sink: strips parity from corrected codewords, drops double-error
// words, buffers good bytes and keeps saturating error counters plus a sticky
// fault flag. Optional macro SECDED_SINK_TAG_EN adds out_corrected per byte.
module secded_word_sink
    import secded_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_is1BitErr,
    input  logic              in_is2BitErr,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  uncorr_count,
    output logic              fault,
    input  logic              clear_fault
`ifdef SECDED_SINK_TAG_EN
    ,
    output logic              out_corrected
`endif
);

`ifdef SECDED_SINK_TAG_EN
    localparam int TAG_W = 1;
`else
    localparam int TAG_W = 0;
`endif
    localparam int FIFO_W = DATA_W + TAG_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              full, empty, accept, push, corr_inc, uncorr_inc;
    logic [FIFO_W-1:0] wdata, rdata;
    logic [CNT_W-1:0]  corr_q, corr_d, uncorr_q, uncorr_d;
    sink_state_t       state_q, state_d;

    // A double-error flag overrides the single-error flag on the same word.
    assign accept     = in_valid & in_ready;
    assign push       = accept & ~in_is2BitErr;
    assign corr_inc   = push & in_is1BitErr;
    assign uncorr_inc = accept & in_is2BitErr;

`ifdef SECDED_SINK_TAG_EN
    assign wdata         = {in_is1BitErr, extract_data(in_code)};
    assign out_data      = rdata[DATA_W-1:0];
    assign out_corrected = rdata[DATA_W];
`else
    assign wdata    = extract_data(in_code);
    assign out_data = rdata;
`endif

    sync_fifo #(.W(FIFO_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .push_i  (push),
        .wdata_i (wdata),
        .pop_i   (out_ready),
        .full_o  (full),
        .empty_o (empty),
        .rdata_o (rdata)
    );

    assign in_ready     = ~full;
    assign out_valid    = ~empty;
    assign corr_count   = corr_q;
    assign uncorr_count = uncorr_q;
    assign fault        = (state_q == FAULT);

    // Saturating counters; clear_fault wins over a same-cycle increment.
    always_comb begin
        corr_d   = corr_q;
        uncorr_d = uncorr_q;
        if (corr_inc && corr_q != CNT_MAX)     corr_d   = corr_q + CNT_W'(1);
        if (uncorr_inc && uncorr_q != CNT_MAX) uncorr_d = uncorr_q + CNT_W'(1);
        if (clear_fault) begin
            corr_d   = '0;
            uncorr_d = '0;
        end
    end

    // Counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            corr_q   <= '0;
            uncorr_q <= '0;
        end else begin
            corr_q   <= corr_d;
            uncorr_q <= uncorr_d;
        end
    end

    // Fault FSM next state; a new double error beats a same-cycle clear.
    always_comb begin
        state_d = state_q;
        if (uncorr_inc)       state_d = FAULT;
        else if (clear_fault) state_d = OK;
    end

    // Fault FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= OK;
        else       state_q <= state_d;
    end

endmodule

// File: tb/tb_secded_word_sink.sv
// Bench for secded_word_sink: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_secded_word_sink;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic        clock, reset, in_valid, in_is1BitErr, in_is2BitErr;
    logic [12:0] in_code;
    logic        in_ready, out_valid, out_ready, fault, clear_fault;
    logic [7:0]  out_data;
    logic [CNT_W-1:0] corr_count, uncorr_count;
`ifdef SECDED_SINK_TAG_EN
    logic        out_corrected;
`endif

    secded_word_sink #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_code      (in_code),
        .in_is1BitErr (in_is1BitErr),
        .in_is2BitErr (in_is2BitErr),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .corr_count   (corr_count),
        .uncorr_count (uncorr_count),
        .fault        (fault),
        .clear_fault  (clear_fault)
`ifdef SECDED_SINK_TAG_EN
        ,
        .out_corrected(out_corrected)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Data byte from a codeword, by arithmetic on bit fields.
    function automatic int ref_data(input int code);
        return ((code >> 3) & 1) | (((code >> 5) & 7) << 1) | (((code >> 9) & 15) << 4);
    endfunction

    // Codeword carrying byte d, with arbitrary parity bits.
    function automatic logic [12:0] make_code(input int d, input int par);
        int c;
        c = ((d & 1) << 3) | (((d >> 1) & 7) << 5) | (((d >> 4) & 15) << 9);
        c = c | (par & 1) | (((par >> 1) & 1) << 1) | (((par >> 2) & 1) << 2) | (((par >> 3) & 1) << 8);
        return 13'(c);
    endfunction

    task automatic idle();
        in_valid = 0; in_code = '0; in_is1BitErr = 0; in_is2BitErr = 0; clear_fault = 0;
    endtask

    task automatic word(input logic [12:0] c, input logic e1, input logic e2);
        in_valid = 1; in_code = c; in_is1BitErr = e1; in_is2BitErr = e2;
    endtask

    typedef struct {
        logic [12:0] code;
        logic        e1, e2;
        logic        ev;
        logic [7:0]  ed;
        int          ec, eu;
        logic        ef, et;
    } vec_t;

    vec_t vt [7];

    // Reference model state.
    int   mq[$];
    int   m_corr, m_unc, m_last;
    bit   m_fault;

    task automatic model_reset();
        mq.delete(); m_corr = 0; m_unc = 0; m_last = 0; m_fault = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bytes [5];
        vt[0] = '{13'h144E, 0, 0, 1, 8'hA5, 0, 0, 0, 0};
        vt[1] = '{13'h144E, 1, 0, 1, 8'hA5, 1, 0, 0, 1};
        vt[2] = '{13'h1FFF, 0, 1, 0, 8'hA5, 1, 1, 1, 1};
        vt[3] = '{13'h1FFF, 0, 0, 1, 8'hFF, 1, 1, 1, 0};
        vt[4] = '{13'h0000, 1, 1, 0, 8'hFF, 1, 2, 1, 0};
        vt[5] = '{13'h0008, 0, 0, 1, 8'h01, 1, 2, 1, 0};
        vt[6] = '{13'h1000, 1, 0, 1, 8'h80, 2, 2, 1, 1};
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        idle(); out_ready = 0; reset = 1;
        repeat (3) @(negedge clock);
        reset = 0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_corr", corr_count, 0);
        chk("rst_uncorr", uncorr_count, 0);
        chk("rst_fault", fault, 0);

        // Vector table, one word per cycle, consumer always ready.
        out_ready = 1;
        for (int i = 0; i < 7; i++) begin
            word(vt[i].code, vt[i].e1, vt[i].e2);
            @(negedge clock);
            chk($sformatf("vec%0d_valid", i), out_valid, vt[i].ev);
            chk($sformatf("vec%0d_data", i), out_data, vt[i].ed);
            chk($sformatf("vec%0d_corr", i), corr_count, vt[i].ec);
            chk($sformatf("vec%0d_uncorr", i), uncorr_count, vt[i].eu);
            chk($sformatf("vec%0d_fault", i), fault, vt[i].ef);
`ifdef SECDED_SINK_TAG_EN
            chk($sformatf("vec%0d_tag", i), out_corrected, vt[i].et);
`endif
        end
        idle();
        @(negedge clock);
        chk("drain_valid", out_valid, 0);
        chk("drain_hold", out_data, 8'h80);

        // clear_fault alone.
        clear_fault = 1;
        @(negedge clock);
        idle();
        chk("clr_fault", fault, 0);
        chk("clr_corr", corr_count, 0);
        chk("clr_uncorr", uncorr_count, 0);

        // Clear with a same-cycle corrected word: clear wins on the counter.
        word(13'h144E, 1, 0); clear_fault = 1;
        @(negedge clock);
        idle();
        chk("clrinc_corr", corr_count, 0);
        chk("clrinc_data", out_data, 8'hA5);
        chk("clrinc_valid", out_valid, 1);

        // Double error then double error with clear: FSM stays in FAULT.
        word(13'h0ABC, 0, 1);
        @(negedge clock);
        chk("de_fault", fault, 1);
        chk("de_uncorr", uncorr_count, 1);
        word(13'h0ABC, 0, 1); clear_fault = 1;
        @(negedge clock);
        chk("declr_fault", fault, 1);
        chk("declr_uncorr", uncorr_count, 0);
        idle(); clear_fault = 1;
        @(negedge clock);
        idle();
        chk("declr2_fault", fault, 0);
        chk("declr2_valid", out_valid, 0);

        // Backpressure up to full.
        out_ready = 0;
        for (int k = 0; k < 4; k++) begin
            word(make_code(bytes[k], k + 3), 0, 0);
            chk($sformatf("bp_ready%0d", k), in_ready, 1);
            @(negedge clock);
        end
        chk("bp_full_ready", in_ready, 0);
        chk("bp_head", out_data, bytes[0]);
        word(make_code(bytes[4], 9), 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("bp_hold_ready", in_ready, 0);
            chk("bp_hold_data", out_data, bytes[0]);
            chk("bp_hold_valid", out_valid, 1);
        end
        idle(); out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp_drain%0d", k), out_data, bytes[k]);
            @(negedge clock);
        end
        chk("bp_drained", out_valid, 0);
        chk("bp_drained_hold", out_data, bytes[3]);

        // Counter saturation.
        for (int k = 0; k < 300; k++) begin
            word(make_code(k & 255, k), 1, 0);
            @(negedge clock);
            if (k == 254) chk("sat_255", corr_count, 255);
        end
        idle();
        @(negedge clock);
        chk("sat_corr", corr_count, 255);
        chk("sat_uncorr", uncorr_count, 0);

        // Reset mid-stream with buffered bytes and a fault.
        out_ready = 0;
        word(make_code(8'h5A, 1), 0, 0); @(negedge clock);
        word(make_code(8'h3C, 2), 0, 0); @(negedge clock);
        word(13'h0123, 0, 1); @(negedge clock);
        idle();
        chk("pre_rst_fault", fault, 1);
        reset = 1;
        @(negedge clock);
        reset = 0;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_data", out_data, 0);
        chk("mrst_corr", corr_count, 0);
        chk("mrst_uncorr", uncorr_count, 0);
        chk("mrst_fault", fault, 0);
        chk("mrst_ready", in_ready, 1);

        // Randomized run against the reference model.
        model_reset();
        for (int n = 0; n < 2000; n++) begin
            int  d;
            bit  v, e1, e2, orr, clr, acc, pop;
            logic [12:0] c;
            chk("rnd_valid", out_valid, mq.size() > 0);
            chk("rnd_data", out_data, m_last & 255);
            chk("rnd_corr", corr_count, m_corr);
            chk("rnd_uncorr", uncorr_count, m_unc);
            chk("rnd_fault", fault, m_fault);
`ifdef SECDED_SINK_TAG_EN
            chk("rnd_tag", out_corrected, (m_last >> 8) & 1);
`endif
            v   = ($urandom_range(0, 9) < 7);
            c   = 13'($urandom);
            e2  = ($urandom_range(0, 9) == 0);
            e1  = ($urandom_range(0, 3) == 0);
            orr = ($urandom_range(0, 99) < ((n / 250) % 2 == 0 ? 30 : 70));
            clr = ($urandom_range(0, 31) == 0);
            in_valid = v; in_code = c; in_is1BitErr = e1; in_is2BitErr = e2;
            out_ready = orr; clear_fault = clr;
            #1;
            chk("rnd_in_ready", in_ready, mq.size() < DEPTH);
            acc = v && (mq.size() < DEPTH);
            pop = orr && (mq.size() > 0);
            if (pop) void'(mq.pop_front());
            if (acc && !e2) begin
                d = ref_data(int'(c));
                mq.push_back(d | (int'(e1) << 8));
                if (e1 && m_corr < 255) m_corr++;
            end
            if (acc && e2 && m_unc < 255) m_unc++;
            if (clr) begin m_corr = 0; m_unc = 0; end
            if (acc && e2) m_fault = 1;
            else if (clr)  m_fault = 0;
            if (mq.size() > 0) m_last = mq[0];
            @(negedge clock);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
